led_current_dac_sched: RTL
==========================

Name: led_current_dac_sched

Overview:
- Schedules delivery of the 8 per-channel LED drive-current codes to the external current DAC over a 3-wire serial link.
- Watches the per-channel change flags raised by the current-setting block and picks one pending channel round-robin.
- Snapshots that channel's current code, shifts one frame to the DAC, then returns the channel number on the readed acknowledge bus so the change flag is cleared.

Parameters:
- CLK_DIV, 4: clk cycles per sclk half-period (≥1).
- GAP_CYC, 2: idle clk cycles with cs_n high between frames (≥1).
- CMD, 4'h3: DAC command nibble placed in frame bits [15:12].

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-low reset.
- enable  in  1  permits starting new frames.
- change  in  8  per-channel update-pending flags; bit i = channel i.
- RDCurrent1d  in  128  packed current codes; channel i at [16i+15:16i].
- readed  out  4  acknowledge; 4'b1000 = none, {1'b0,ch} = channel ch delivered.
- dac_cs_n  out  1  DAC chip select, active low.
- dac_sclk  out  1  serial clock, idles low.
- dac_mosi  out  1  serial data, MSB first.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (reset==0 at posedge): takes effect on the next edge, including mid-frame.
  - state=IDLE, dac_cs_n=1, dac_sclk=0, dac_mosi=0, readed=4'b1000, busy=0.
  - Round-robin pointer=7, so channel 0 has first priority.
- States: IDLE -> SETUP -> SHIFT -> HOLD -> ACK -> GAP -> IDLE.
- IDLE: if enable && |change, grant the first set bit searching ptr+1, ptr+2, … mod 8.
  - Latch ch and frame = {CMD, 1'b0, ch[2:0], code}.
  - code = RDCurrent[ch][7:0] if RDCurrent[ch][15:8]==0, else 8'hFF (saturate).
  - ptr<=ch; go to SETUP.
- SETUP: dac_cs_n=0, dac_mosi=frame[15], sclk low; lasts CLK_DIV cycles.
- SHIFT: 16 bits, 2*CLK_DIV cycles per bit.
  - sclk low for the first CLK_DIV cycles, high for the second.
  - mosi updates only while sclk is low, at the start of each bit; the DAC samples on the rising edge.
  - After bit 0's high phase, sclk=0 and go to HOLD.
- HOLD: cs_n stays low for CLK_DIV cycles, then cs_n=1.
- ACK: exactly one cycle. Recompute the saturated code of channel ch from live RDCurrent1d.
  - If equal to the sent code, readed={1'b0,ch}.
  - Otherwise readed stays 4'b1000: change[ch] remains set, and the channel is re-sent later in round-robin order. No stale acknowledge is issued.
- GAP: GAP_CYC cycles with readed=4'b1000, then IDLE.
  - GAP≥1 guarantees the flag clear from the acknowledge is visible before the next arbitration.
- Latency and frame length:
  - cs_n falls 1 clk after the IDLE grant cycle.
  - Frame occupancy (SETUP through HOLD) = 34*CLK_DIV cycles.
  - Full slot = 34*CLK_DIV + 1 + GAP_CYC cycles after the grant cycle.
- enable deasserted mid-frame: the frame completes, including ACK; no new grant until enable=1.
- change[ch] dropping mid-frame: ignored; the frame completes and is still acknowledged (harmless clear).
- Simultaneous requests: exactly one grant per slot. Every pending channel is served within 8 slots (no starvation).
- The arbiter's grant decision is ignored outside IDLE.

Decomposition:
- Shared package:
  - READED_NONE = 4'b1000.
  - FRAME_W = 16.
  - State encoding enum (IDLE, SETUP, SHIFT, HOLD, ACK, GAP).
  - Channel count NCH = 8.
- One sub-module: rr_arb8. Inputs are an 8-bit request vector and a 3-bit pointer; outputs are a valid bit and a 3-bit grant; purely combinational.
- Pointer register, frame shifter and FSM stay in the top module.

Test Plan:
- Reset behaviour: hold reset=0 for 3 cycles with change=8'hFF.
  - All outputs take their idle values: readed=4'b1000, cs_n=1, sclk=0, busy=0.
  - No frame starts until reset=1.
- Single update: CLK_DIV=2, change=8'b0000_0100, RDCurrent[2]=16'h0081.
  - Bits captured on sclk rising edges = 16'h3281.
  - cs_n is low for 68 cycles.
  - readed=4'b0010 for exactly 1 cycle, then 4'b1000.
- Fairness: change=8'b1000_0001, held until acknowledged.
  - Grant order is ch0 then ch7.
  - Re-asserting both after ch7 grants ch0 next.
  - change=8'hFF yields the order 0,1,…,7.
- Stale value: RDCurrent[5] changes 16'h0080->16'h0081 during the SHIFT of ch5.
  - No acknowledge in ACK.
  - The next ch5 frame carries 16'h3581 and is acknowledged with readed=4'b0101.
- Saturation: RDCurrent[1]=16'h0123 gives frame 16'h31FF.
- Interruptions:
  - enable=0 during SHIFT: the frame and its acknowledge complete, then no further frames.
  - reset=0 during SHIFT: the next edge gives cs_n=1, sclk=0, readed=4'b1000, and the pointer restarts at channel 0.

Source files
------------

// File: rtl/led_current_dac_sched_pkg.sv
// Shared types and constants for the LED current DAC scheduler.
// Holds the state encoding, the channel and frame sizes, and the code saturation helper.
package led_current_dac_sched_pkg;

    localparam int          NCH         = 8;
    localparam int          CH_W        = 3;
    localparam int          FRAME_W     = 16;
    localparam logic [3:0]  READED_NONE = 4'b1000;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        SHIFT,
        HOLD,
        ACK,
        GAP
    } state_t;

    // Codes wider than 8 bits clamp to full scale instead of wrapping.
    function automatic logic [7:0] sat_code(input logic [FRAME_W-1:0] cur);
        return (cur[15:8] == 8'h00) ? cur[7:0] : 8'hFF;
    endfunction

endpackage

// File: rtl/led_current_dac_sched_if.sv
// Link between the current-setting block and the DAC scheduler:
// change flags and current codes in, per-channel delivery acknowledge out.
interface led_current_dac_sched_if;
    import led_current_dac_sched_pkg::*;

    logic                   enable;
    logic [NCH-1:0]         change;
    logic [NCH*FRAME_W-1:0] RDCurrent1d;
    logic [3:0]             readed;

    modport master (output enable, output change, output RDCurrent1d, input readed);
    modport slave  (input enable, input change, input RDCurrent1d, output readed);

endinterface

// File: rtl/led_current_dac_sched_rr_arb8.sv
// Round-robin pick of one of 8 requests, searching ptr+1, ptr+2, ... (mod 8).
// Latency: purely combinational.
// Backpressure: none; the caller decides when the grant is used.
module rr_arb8
    import led_current_dac_sched_pkg::*;
(
    input  logic [NCH-1:0]  req,
    input  logic [CH_W-1:0] ptr,
    output logic            gnt_vld,
    output logic [CH_W-1:0] gnt
);

    logic [CH_W-1:0] idx;

    // Scanning from the farthest position back means the nearest request is written last and wins.
    always_comb begin
        gnt_vld = 1'b0;
        gnt     = '0;
        idx     = '0;
        for (int i = NCH; i >= 1; i--) begin
            idx = ptr + CH_W'(i);
            if (req[idx]) begin
                gnt_vld = 1'b1;
                gnt     = idx;
            end
        end
    end

endmodule

// File: rtl/led_current_dac_sched.sv
// Sends pending LED current codes to the serial DAC, one round-robin channel per frame, then acknowledges it.
// Latency: cs_n falls 1 clk after the grant; a slot lasts 34*CLK_DIV + 1 + GAP_CYC clk after the grant.
// Backpressure: new grants need enable and an idle FSM; a frame in flight always completes.
module led_current_dac_sched
    import led_current_dac_sched_pkg::*;
#(
    parameter int         CLK_DIV = 4,
    parameter int         GAP_CYC = 2,
    parameter logic [3:0] CMD     = 4'h3
) (
    input  logic                   clk,
    input  logic                   reset,
    led_current_dac_sched_if.slave cur,
    output logic                   dac_cs_n,
    output logic                   dac_sclk,
    output logic                   dac_mosi,
    output logic                   busy
);

    localparam int CNT_MAX = (2 * CLK_DIV > GAP_CYC) ? 2 * CLK_DIV : GAP_CYC;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(2 * CLK_DIV - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYC - 1);

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [3:0]           bit_q, bit_d;
    logic [CH_W-1:0]      ptr_q, ptr_d;
    logic [CH_W-1:0]      ch_q, ch_d;
    logic [FRAME_W-1:0]   frame_q, frame_d;
    logic                 cs_n_q, cs_n_d;
    logic                 sclk_q, sclk_d;
    logic                 mosi_q, mosi_d;

    logic                 gnt_vld;
    logic [CH_W-1:0]      gnt;
    logic [7:0]           gnt_code;
    logic [7:0]           live_code;

    rr_arb8 u_arb (
        .req     (cur.change),
        .ptr     (ptr_q),
        .gnt_vld (gnt_vld),
        .gnt     (gnt)
    );

    assign gnt_code  = sat_code(cur.RDCurrent1d[{gnt, 4'b0000} +: FRAME_W]);
    assign live_code = sat_code(cur.RDCurrent1d[{ch_q, 4'b0000} +: FRAME_W]);

    // Only acknowledge if the DAC now holds what the channel currently asks for.
    assign cur.readed = (state_q == ACK && live_code == frame_q[7:0]) ? {1'b0, ch_q} : READED_NONE;
    assign busy       = (state_q != IDLE);
    assign dac_cs_n   = cs_n_q;
    assign dac_sclk   = sclk_q;
    assign dac_mosi   = mosi_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        ptr_d   = ptr_q;
        ch_d    = ch_q;
        frame_d = frame_q;
        cs_n_d  = cs_n_q;
        sclk_d  = sclk_q;
        mosi_d  = mosi_q;
        unique case (state_q)
            IDLE: begin
                cs_n_d = 1'b1;
                sclk_d = 1'b0;
                mosi_d = 1'b0;
                if (cur.enable && gnt_vld) begin
                    ch_d    = gnt;
                    ptr_d   = gnt;
                    frame_d = {CMD, 1'b0, gnt, gnt_code};
                    cs_n_d  = 1'b0;
                    mosi_d  = CMD[3];
                    cnt_d   = '0;
                    state_d = SETUP;
                end
            end
            SETUP: begin
                if (cnt_q == HALF_LAST) begin
                    cnt_d   = '0;
                    bit_d   = 4'd15;
                    state_d = SHIFT;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            SHIFT: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d  = '0;
                    sclk_d = 1'b0;
                    if (bit_q == 4'd0) begin
                        state_d = HOLD;
                    end else begin
                        bit_d  = bit_q - 4'd1;
                        mosi_d = frame_q[bit_q - 4'd1];
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == HALF_LAST) begin
                        sclk_d = 1'b1;
                    end
                end
            end
            HOLD: begin
                if (cnt_q == HALF_LAST) begin
                    cnt_d   = '0;
                    cs_n_d  = 1'b1;
                    mosi_d  = 1'b0;
                    state_d = ACK;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ACK: begin
                cnt_d   = '0;
                state_d = GAP;
            end
            GAP: begin
                if (cnt_q == GAP_LAST) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            ptr_q   <= CH_W'(NCH - 1);
            ch_q    <= '0;
            frame_q <= '0;
            cs_n_q  <= 1'b1;
            sclk_q  <= 1'b0;
            mosi_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            ptr_q   <= ptr_d;
            ch_q    <= ch_d;
            frame_q <= frame_d;
            cs_n_q  <= cs_n_d;
            sclk_q  <= sclk_d;
            mosi_q  <= mosi_d;
        end
    end

endmodule
